// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges two ALU pipe results with long-latency results
// buffered in a small FIFO, and drives the two register-file write ports.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     PV1,
   input  logic [AW-1:0]            PA1,
   input  logic [DW-1:0]            PD1,
   input  logic                     PV2,
   input  logic [AW-1:0]            PA2,
   input  logic [DW-1:0]            PD2,
   input  logic                     LV,
   input  logic [AW-1:0]            LA,
   input  logic [DW-1:0]            LD,
   output logic                     LRdy,
   input  logic [AW-1:0]            QA1,
   input  logic [AW-1:0]            QA2,
   output logic                     QPend1,
   output logic                     QPend2,
   output logic                     WE1,
   output logic [AW-1:0]            WA1,
   output logic [DW-1:0]            WD1,
   output logic                     WE2,
   output logic [AW-1:0]            WA2,
   output logic [DW-1:0]            WD2,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] mem_addr [DEPTH];
   logic [DW-1:0] mem_data [DEPTH];

   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;

   logic [PW-1:0] head1_idx;
   logic          has0;
   logic          has1;
   logic          enqueue;
   logic          pipe1_ok;
   logic          pipe2_ok;

   logic          sel1_v;
   logic          sel1_fifo;
   logic [AW-1:0] sel1_a;
   logic [DW-1:0] sel1_d;
   logic          sel2_v;
   logic          sel2_fifo;
   logic [AW-1:0] sel2_a;
   logic [DW-1:0] sel2_d;
   logic [1:0]    deq_n;
   logic          same_addr;
   logic          p1_younger;
   logic          keep1;
   logic          keep2;

   assign Count     = count_reg;
   assign LRdy      = !Reset && (count_reg < CW'(DEPTH));
   assign enqueue   = LV && LRdy && (LA != '0);
   assign head1_idx = rd_ptr_reg + 1'b1;
   assign has0      = (count_reg != '0);
   assign has1      = (count_reg >= CW'(2));
   assign pipe1_ok  = PV1 && (PA1 != '0);
   assign pipe2_ok  = PV2 && (PA2 != '0);

   // Slot allocation: FIFO entries fill idle slots oldest-first, slot 1 first.
   always_comb begin
      sel1_v    = 1'b0;
      sel1_fifo = 1'b0;
      sel1_a    = PA1;
      sel1_d    = PD1;
      sel2_v    = 1'b0;
      sel2_fifo = 1'b0;
      sel2_a    = PA2;
      sel2_d    = PD2;
      deq_n     = 2'd0;

      if (pipe1_ok) begin
         sel1_v = 1'b1;
      end else if (has0) begin
         sel1_v    = 1'b1;
         sel1_fifo = 1'b1;
         sel1_a    = mem_addr[rd_ptr_reg];
         sel1_d    = mem_data[rd_ptr_reg];
         deq_n     = 2'd1;
      end

      if (pipe2_ok) begin
         sel2_v = 1'b1;
      end else if (deq_n == 2'd0 && has0) begin
         sel2_v    = 1'b1;
         sel2_fifo = 1'b1;
         sel2_a    = mem_addr[rd_ptr_reg];
         sel2_d    = mem_data[rd_ptr_reg];
         deq_n     = 2'd1;
      end else if (deq_n == 2'd1 && has1) begin
         sel2_v    = 1'b1;
         sel2_fifo = 1'b1;
         sel2_a    = mem_addr[head1_idx];
         sel2_d    = mem_data[head1_idx];
         deq_n     = 2'd2;
      end
   end

   // Port 1 only wins a same-address conflict when it carries pipe 1 against a FIFO entry.
   assign same_addr  = sel1_v && sel2_v && (sel1_a == sel2_a);
   assign p1_younger = !sel1_fifo && sel2_fifo;
   assign keep1      = sel1_v && !(same_addr && !p1_younger);
   assign keep2      = sel2_v && !(same_addr && p1_younger);

   always_ff @(posedge Clk) begin
      if (enqueue) begin
         mem_addr[wr_ptr_reg] <= LA;
         mem_data[wr_ptr_reg] <= LD;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         WE1        <= 1'b0;
         WA1        <= '0;
         WD1        <= '0;
         WE2        <= 1'b0;
         WA2        <= '0;
         WD2        <= '0;
      end else begin
         if (enqueue) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         rd_ptr_reg <= rd_ptr_reg + PW'(deq_n);
         count_reg  <= count_reg + CW'(enqueue) - CW'(deq_n);
         WE1        <= keep1;
         WE2        <= keep2;
         if (keep1) begin
            WA1 <= sel1_a;
            WD1 <= sel1_d;
         end
         if (keep2) begin
            WA2 <= sel2_a;
            WD2 <= sel2_d;
         end
      end
   end

   logic [DEPTH-1:0] hit1;
   logic [DEPTH-1:0] hit2;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
         logic [PW-1:0] offset;
         logic          live;
         assign offset   = PW'(gi) - rd_ptr_reg;
         assign live     = (CW'(offset) < count_reg);
         assign hit1[gi] = live && (mem_addr[gi] == QA1);
         assign hit2[gi] = live && (mem_addr[gi] == QA2);
      end
   endgenerate

   assign QPend1 = (QA1 != '0) &&
                   ((|hit1) || (WE1 && WA1 == QA1) || (WE2 && WA2 == QA1));
   assign QPend2 = (QA2 != '0) &&
                   ((|hit2) || (WE1 && WA1 == QA2) || (WE2 && WA2 == QA2));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed steps followed by random traffic,
// compared against a queue-based reference model.
module tb_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          PV1, PV2, LV;
   logic [AW-1:0] PA1, PA2, LA, QA1, QA2;
   logic [DW-1:0] PD1, PD2, LD;
   logic          LRdy, QPend1, QPend2, WE1, WE2;
   logic [AW-1:0] WA1, WA2;
   logic [DW-1:0] WD1, WD2;
   logic [CW-1:0] Count;

   always #5 Clk = ~Clk;

   wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .Clk(Clk), .Reset(Reset),
      .PV1(PV1), .PA1(PA1), .PD1(PD1),
      .PV2(PV2), .PA2(PA2), .PD2(PD2),
      .LV(LV), .LA(LA), .LD(LD), .LRdy(LRdy),
      .QA1(QA1), .QA2(QA2), .QPend1(QPend1), .QPend2(QPend2),
      .WE1(WE1), .WA1(WA1), .WD1(WD1),
      .WE2(WE2), .WA2(WA2), .WD2(WD2),
      .Count(Count)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q[$];
   logic          exp_we1, exp_we2;
   logic [AW-1:0] exp_wa1, exp_wa2;
   logic [DW-1:0] exp_wd1, exp_wd2;
   int            tests = 0;
   int            fails = 0;
   bit            hs;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pend(input logic [AW-1:0] a);
      if (a == '0) return 1'b0;
      foreach (q[i]) if (q[i].a == a) return 1'b1;
      return (exp_we1 && exp_wa1 == a) || (exp_we2 && exp_wa2 == a);
   endfunction

   task automatic idle();
      PV1 = 0; PA1 = '0; PD1 = '0;
      PV2 = 0; PA2 = '0; PD2 = '0;
      LV  = 0; LA  = '0; LD  = '0;
      QA1 = '0; QA2 = '0;
   endtask

   // One clock: check combinational outputs, then the registered result of this cycle.
   task automatic tick();
      bit            lrdy;
      ent_t          c[2];
      bit            cv[2];
      int            rk[2];
      int            take;
      logic [AW-1:0] la;
      logic [DW-1:0] ld;
      #1;
      lrdy = !Reset && (q.size() < DEPTH);
      chk("lrdy", 64'(LRdy), 64'(lrdy));
      chk("count", 64'(Count), 64'(q.size()));
      chk("qpend1", 64'(QPend1), 64'(pend(QA1)));
      chk("qpend2", 64'(QPend2), 64'(pend(QA2)));
      hs = LV && lrdy;
      la = LA;
      ld = LD;
      cv[0] = 0; cv[1] = 0; rk[0] = 0; rk[1] = 0; take = 0;
      c[0] = '{a: '0, d: '0};
      c[1] = '{a: '0, d: '0};
      if (PV1 && PA1 != '0) begin
         c[0] = '{a: PA1, d: PD1}; cv[0] = 1; rk[0] = 100;
      end else if (take < q.size()) begin
         c[0] = q[take]; cv[0] = 1; rk[0] = take; take++;
      end
      if (PV2 && PA2 != '0) begin
         c[1] = '{a: PA2, d: PD2}; cv[1] = 1; rk[1] = 101;
      end else if (take < q.size()) begin
         c[1] = q[take]; cv[1] = 1; rk[1] = take; take++;
      end
      if (cv[0] && cv[1] && c[0].a == c[1].a) begin
         if (rk[0] < rk[1]) cv[0] = 0;
         else cv[1] = 0;
      end
      @(posedge Clk);
      #1;
      if (Reset) begin
         q.delete();
         exp_we1 = 0; exp_wa1 = '0; exp_wd1 = '0;
         exp_we2 = 0; exp_wa2 = '0; exp_wd2 = '0;
      end else begin
         for (int i = 0; i < take; i++) void'(q.pop_front());
         if (hs && la != '0) q.push_back('{a: la, d: ld});
         exp_we1 = cv[0];
         if (cv[0]) begin exp_wa1 = c[0].a; exp_wd1 = c[0].d; end
         exp_we2 = cv[1];
         if (cv[1]) begin exp_wa2 = c[1].a; exp_wd2 = c[1].d; end
      end
      chk("we1", 64'(WE1), 64'(exp_we1));
      chk("wa1", 64'(WA1), 64'(exp_wa1));
      chk("wd1", 64'(WD1), 64'(exp_wd1));
      chk("we2", 64'(WE2), 64'(exp_we2));
      chk("wa2", 64'(WA2), 64'(exp_wa2));
      chk("wd2", 64'(WD2), 64'(exp_wd2));
   endtask

   initial begin
      int acc;
      int dens;
      Reset = 1;
      idle();
      repeat (3) @(posedge Clk);
      #1;
      exp_we1 = 0; exp_wa1 = '0; exp_wd1 = '0;
      exp_we2 = 0; exp_wa2 = '0; exp_wd2 = '0;
      tick();
      chk("rst_count", 64'(Count), 64'd0);
      chk("rst_we1", 64'(WE1), 64'd0);
      Reset = 0;

      // Two pipe results, one cycle latency.
      PV1 = 1; PA1 = 5'd1; PD1 = 32'h6969ffff;
      PV2 = 1; PA2 = 5'd2; PD2 = 32'haaaaaaaa;
      tick();
      chk("t1_wd1", 64'(WD1), 64'h6969ffff);
      chk("t1_wd2", 64'(WD2), 64'haaaaaaaa);
      idle();
      tick();
      chk("t1_we1_off", 64'(WE1), 64'd0);

      // Two long-latency pushes through an otherwise idle arbiter.
      QA1 = 5'd3;
      LV = 1; LA = 5'd3; LD = 32'h42042069;
      tick();
      LA = 5'd4; LD = 32'h33229999;
      tick();
      chk("t2_count", 64'(Count), 64'd1);
      LV = 0;
      chk("t2_wa1", 64'(WA1), 64'd3);
      repeat (3) tick();

      // Fill the FIFO while both pipes are busy, then free port 2.
      PV1 = 1; PA1 = 5'd5; PV2 = 1; PA2 = 5'd6;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         PD1 = $urandom; PD2 = $urandom;
         LV = 1; LA = AW'(8 + acc); LD = $urandom;
         tick();
         if (hs) acc++;
      end
      #1;
      chk("t3_full_count", 64'(Count), 64'd4);
      chk("t3_full_lrdy", 64'(LRdy), 64'd0);
      PV2 = 0;
      for (int i = 0; i < 8; i++) begin
         if (acc >= 5) LV = 0;
         else LA = AW'(8 + acc);
         tick();
         if (hs && LV) acc++;
      end
      idle();
      repeat (2) tick();

      // Same-address pipe conflict: younger pipe 2 wins.
      PV1 = 1; PA1 = 5'd7; PD1 = 32'd1;
      PV2 = 1; PA2 = 5'd7; PD2 = 32'd2;
      tick();
      chk("t4_we1", 64'(WE1), 64'd0);
      chk("t4_we2", 64'(WE2), 64'd1);
      chk("t4_wd2", 64'(WD2), 64'd2);
      idle();

      // Writes to register 0 are dropped.
      PV1 = 1; PA1 = '0; PD1 = 32'hdead;
      LV = 1; LA = '0; LD = 32'hbeef;
      tick();
      chk("t5_we1", 64'(WE1), 64'd0);
      chk("t5_count", 64'(Count), 64'd0);
      idle();

      // Reset with three entries queued.
      PV1 = 1; PA1 = 5'd9; PV2 = 1; PA2 = 5'd10;
      for (int i = 0; i < 3; i++) begin
         LV = 1; LA = AW'(11 + i); LD = $urandom;
         tick();
      end
      chk("t6_count3", 64'(Count), 64'd3);
      Reset = 1;
      tick();
      Reset = 0;
      idle();
      repeat (3) tick();
      chk("t6_we1", 64'(WE1), 64'd0);
      chk("t6_we2", 64'(WE2), 64'd0);
      chk("t6_count", 64'(Count), 64'd0);

      // Random traffic with varying pipe density and occasional reset.
      dens = 2;
      for (int i = 0; i < 800; i++) begin
         if (i % 40 == 0) dens = $urandom_range(0, 4);
         Reset = ($urandom_range(0, 63) == 0);
         PV1 = ($urandom_range(0, 3) < dens); PA1 = AW'($urandom_range(0, 7)); PD1 = $urandom;
         PV2 = ($urandom_range(0, 3) < dens); PA2 = AW'($urandom_range(0, 7)); PD2 = $urandom;
         LV  = ($urandom_range(0, 1) == 1);   LA  = AW'($urandom_range(0, 7)); LD  = $urandom;
         QA1 = AW'($urandom_range(0, 7));
         QA2 = AW'($urandom_range(0, 7));
         tick();
      end
      Reset = 0;
      idle();
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back arbitration stage that sits directly upstream of the dual-write-port register file and drives its WE1/WE2/WA1/WA2/WD1/WD2 inputs. It merges results from the two ALU pipes with results from the long-latency unit (mul/div). Long-latency results are held in a small FIFO and drained into whichever write ports the pipes leave idle. The block also reports pending writes to the issue logic.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
PV1  in  1  pipe 1 result valid
PA1  in  AW  pipe 1 destination register
PD1  in  DW  pipe 1 result data
PV2  in  1  pipe 2 result valid (pipe 2 is younger than pipe 1)
PA2  in  AW  pipe 2 destination register
PD2  in  DW  pipe 2 result data
LV  in  1  long-latency result valid
LA  in  AW  long-latency destination register
LD  in  DW  long-latency result data
LRdy  out  1  FIFO can accept; transfer occurs when LV && LRdy
QA1  in  AW  issue query address 1
QA2  in  AW  issue query address 2
QPend1  out  1  write to QA1 still pending (combinational)
QPend2  out  1  write to QA2 still pending (combinational)
WE1  out  1  register file write enable, port 1 (registered)
WA1  out  AW  register file write address, port 1 (registered)
WD1  out  DW  register file write data, port 1 (registered)
WE2  out  1  register file write enable, port 2 (registered)
WA2  out  AW  register file write address, port 2 (registered)
WD2  out  DW  register file write data, port 2 (registered)
Count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clocking/reset: one clock, Clk. Reset is synchronous and active-high.
- Reset effects: clears FIFO pointers; Count=0; WE1=WE2=0; WA1/WA2=0; WD1/WD2=0. LRdy=0 while Reset is high.
- Reset mid-operation: all FIFO contents are discarded and no write is issued on the following cycle.
- LRdy = !Reset && (Count < DEPTH), from the start-of-cycle Count only. A same-cycle dequeue never frees room for an enqueue when the FIFO is full.
- Register 0: any write with address 0 is dropped.
  - Pipe input: that port slot counts as idle.
  - Long-latency input: the handshake still completes but nothing is enqueued.
- Port allocation, per cycle, from start-of-cycle state:
  - slot1 = PV1 && PA1!=0 ? pipe 1 : idle
  - slot2 = PV2 && PA2!=0 ? pipe 2 : idle
  - The oldest FIFO entry fills the first idle slot, slot1 before slot2. The next-oldest fills the remaining idle slot. Maximum of 2 dequeues per cycle.
- Same-address conflict: if both selected writes target the same register, keep the younger one and drop the other (WE low on the dropped port). Age order, oldest to youngest: FIFO entries, then pipe 1, then pipe 2. Dropped FIFO entries are still dequeued.
- Latency:
  - Pipe result at cycle N is on WE/WA/WD at N+1 (written to the register file at the end of N+1).
  - A long-latency result enqueued at N is eligible for dequeue at N+1 and appears on the outputs at N+2 at the earliest. There is no FIFO bypass.
- Enqueue and dequeue in the same cycle are legal. Count updates by enqueue minus dequeues.
- FIFO pointers wrap modulo DEPTH. Full is Count==DEPTH; empty is Count==0.
- QPendk = (QAk != 0) && (a valid FIFO entry has address QAk, OR (WE1 && WA1==QAk), OR (WE2 && WA2==QAk)).
- Unused output port: WE low; WA/WD hold their previous values.

Test Plan:
- Reset, then PV1=1 PA1=1 PD1=32'h6969ffff and PV2=1 PA2=2 PD2=32'haaaaaaaa for 1 cycle -> next cycle WE1=1 WA1=1 WD1=32'h6969ffff, WE2=1 WA2=2 WD2=32'haaaaaaaa; the cycle after, WE1=WE2=0.
- Pipes idle; push LA=3 LD=32'h42042069 then LA=4 LD=32'h33229999 on consecutive cycles -> Count reaches 1 then 1; writes appear on port 1 two cycles after each push; QPend1 high for QA1=3 from push+1 until the write cycle ends.
- Hold PV1=PV2=1 (addresses 5,6); push 5 long-latency results -> LRdy drops after 4 accepted, Count=4, the 5th is held. Release PV2 -> one dequeue per cycle on port 2, in FIFO order.
- PV1=1 PA1=7 PD1=1 and PV2=1 PA2=7 PD2=2 in the same cycle -> WE1=0, WE2=1 WA2=7 WD2=2.
- PA1=0 PV1=1, and a long-latency push with LA=0 -> WE1=0, Count unchanged, handshake completes (LRdy=1).
- FIFO holding 3 entries, assert Reset for 1 cycle -> Count=0, WE1=WE2=0, LRdy=0 during reset and 1 after; no stale writes afterwards.
